// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Next-PC selection and IF/ID pipeline register with stall and
//            branch/jump redirect. Optional perf counters under FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        hd_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] pc_next_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o,
    output logic        flush_o
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] w_pc4;
    logic [31:0] w_pc_next_raw;
    logic        w_flush;
    logic        w_load;
    logic        w_stall;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    assign w_pc4 = pc_i + 32'd4;

    always_comb begin
        w_state_next  = r_state;
        w_pc_next_raw = RESET_VEC;
        w_flush       = 1'b0;
        w_load        = 1'b0;
        w_stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_state_next = RUN;
            end
            RUN: begin
                // Stall outranks redirect: the branch is re-presented once hd_i drops.
                if (hd_i) begin
                    w_pc_next_raw = pc_i;
                    w_stall       = 1'b1;
                end else if (jump_i) begin
                    w_pc_next_raw = jump_addr_i;
                    w_flush       = 1'b1;
                end else if (branch_i) begin
                    w_pc_next_raw = branch_addr_i;
                    w_flush       = 1'b1;
                end else begin
                    w_pc_next_raw = w_pc4;
                    w_load        = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (r_state == IDLE) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= w_pc4;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_instr <= instr_i;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
        end
    end

    assign pc_next_o = w_pc_next_raw & c_ALIGN_MASK;
    assign instr_o   = r_instr;
    assign pc4_o     = r_pc4;
    assign valid_o   = r_valid;
    assign flush_o   = w_flush;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_load)  r_fetch_cnt <= r_fetch_cnt + 1'b1;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl with directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] c_NOP       = 32'h0000_0000;
    localparam int          c_CNT_W     = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic        hd_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [31:0] pc_next_o;
    logic [31:0] instr_o;
    logic [31:0] pc4_o;
    logic        valid_o;
    logic        flush_o;
`ifdef FETCH_PERF_EN
    logic [c_CNT_W-1:0] fetch_cnt_o;
    logic [c_CNT_W-1:0] stall_cnt_o;
    logic [c_CNT_W-1:0] flush_cnt_o;
`endif

    fetch_ctrl #(
        .RESET_VEC(c_RESET_VEC),
        .NOP_INSTR(c_NOP),
        .CNT_W    (c_CNT_W)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .hd_i         (hd_i),
        .branch_i     (branch_i),
        .branch_addr_i(branch_addr_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .pc_next_o    (pc_next_o),
        .instr_o      (instr_o),
        .pc4_o        (pc4_o),
        .valid_o      (valid_o),
        .flush_o      (flush_o)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc_next;
        logic        flush;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: abstract pipeline state, advanced once per issued cycle.
    bit          m_run   = 1'b0;
    logic [31:0] m_instr = c_NOP;
    logic [31:0] m_pc4   = 32'd0;
    bit          m_valid = 1'b0;
    logic [31:0] m_pc    = 32'd0;
    int unsigned m_fetch = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_instr = c_NOP;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_pc    = c_RESET_VEC;
        m_fetch = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic step(input logic st, input logic [31:0] pc, input logic [31:0] ins,
                        input logic hd, input logic br, input logic [31:0] ba,
                        input logic jp, input logic [31:0] ja);
        exp_t        e;
        logic [31:0] nxt;
        logic        fl;
        @(posedge clk_i);
        #1;
        start_i = st; pc_i = pc; instr_i = ins; hd_i = hd;
        branch_i = br; branch_addr_i = ba; jump_i = jp; jump_addr_i = ja;
        fl = 1'b0;
        if (!m_run)    nxt = c_RESET_VEC;
        else if (hd)   nxt = pc;
        else if (jp) begin nxt = ja; fl = 1'b1; end
        else if (br) begin nxt = ba; fl = 1'b1; end
        else           nxt = pc + 32'd4;
        nxt = {nxt[31:2], 2'b00};
        e.pc_next = nxt;
        e.flush   = fl;
        e.instr   = m_instr;
        e.pc4     = m_pc4;
        e.valid   = m_valid;
        sb_q.push_back(e);
        if (!m_run) begin
            m_instr = c_NOP; m_valid = 1'b0; m_run = st;
        end else if (fl) begin
            m_instr = c_NOP; m_valid = 1'b0; m_pc4 = pc + 32'd4; m_flush++;
        end else if (!hd) begin
            m_instr = ins; m_valid = 1'b1; m_pc4 = pc + 32'd4; m_fetch++;
        end else begin
            m_stall++;
        end
        m_pc = nxt;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pc_next", pc_next_o, e.pc_next);
                check("flush",   {31'd0, flush_o}, {31'd0, e.flush});
                check("instr",   instr_o, e.instr);
                check("pc4",     pc4_o, e.pc4);
                check("valid",   {31'd0, valid_o}, {31'd0, e.valid});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] r;
        model_reset();
        #3;
        check("rst_instr",   instr_o, c_NOP);
        check("rst_pc4",     pc4_o, 32'd0);
        check("rst_valid",   {31'd0, valid_o}, 32'd0);
        check("rst_pc_next", pc_next_o, c_RESET_VEC);
        check("rst_flush",   {31'd0, flush_o}, 32'd0);
        #9 rst_i = 1'b0;

        // start-up and sequential fetch
        step(1'b1, 32'h0,  32'h2001_0001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0,  32'h2002_0002, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h4,  32'h2003_0003, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'hC,  32'h2004_0004, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // two-cycle stall
        step(1'b0, 32'h10, 32'h2005_0005, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h10, 32'h2005_0005, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h10, 32'h2005_0005, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // branch redirect
        step(1'b0, 32'h20, 32'h2006_0006, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        step(1'b0, 32'h80, 32'h2007_0007, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // priority: stall beats jump and branch, then jump beats branch
        step(1'b0, 32'h84, 32'h2008_0008, 1'b1, 1'b1, 32'h80, 1'b1, 32'h200);
        step(1'b0, 32'h84, 32'h2008_0008, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200);
        // wrap-around and target alignment
        step(1'b0, 32'hFFFF_FFFC, 32'h2009_0009, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h200A_000A, 1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
        step(1'b0, 32'h100, 32'h200B_000B, 1'b0, 1'b1, 32'h2_0007, 1'b0, 32'h0);
        // second start while running
        step(1'b1, 32'h2_0004, 32'h200C_000C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom();
            pc = (r[3:0] == 4'hF) ? 32'hFFFF_FFFC :
                 (r[4] ? m_pc : ($urandom() & 32'hFFFF_FFFC));
            step(r[31:28] == 4'h0, pc, $urandom(),
                 r[27:26] == 2'b00, r[25:23] < 3'd2, $urandom(),
                 r[22:20] == 3'd0, $urandom());
        end

        // asynchronous reset in the middle of a stall
        step(1'b0, m_pc, 32'h3001_0001, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drain();
        #1 rst_i = 1'b1;
        #1;
        check("arst_valid",   {31'd0, valid_o}, 32'd0);
        check("arst_instr",   instr_o, c_NOP);
        check("arst_pc4",     pc4_o, 32'd0);
        check("arst_pc_next", pc_next_o, c_RESET_VEC);
        check("arst_flush",   {31'd0, flush_o}, 32'd0);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        model_reset();

        // idle ignores hazards; start and hd together still starts
        step(1'b0, 32'h40, 32'h3002_0002, 1'b1, 1'b1, 32'h44, 1'b1, 32'h48);
        step(1'b1, 32'h0,  32'h3003_0003, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            step(1'b0, r[4] ? m_pc : ($urandom() & 32'hFFFF_FFFC), $urandom(),
                 r[27:26] == 2'b00, r[25:23] < 3'd2, $urandom(),
                 r[22:20] == 3'd0, $urandom());
        end

        @(posedge clk_i);
        #1;
        if (sb_q.size() != 0) drain();
`ifdef FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt_o, m_fetch);
        check("stall_cnt", stall_cnt_o, m_stall);
        check("flush_cnt", flush_cnt_o, m_flush);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
